// File: rtl/key_char_fifo_if.sv
// Keyboard-event / character-stream bundle for key_char_fifo.
// master = event source and character consumer, slave = key_char_fifo.
interface key_char_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          key_valid;
  logic [8:0]    last_change;
  logic          key_make;
  logic          char_ready;
  logic [7:0]    char_data;
  logic          char_valid;
  logic [CW-1:0] char_count;
  logic          overflow;

  modport master (
    output key_valid, last_change, key_make, char_ready,
    input  char_data, char_valid, char_count, overflow
  );

  modport slave (
    input  key_valid, last_change, key_make, char_ready,
    output char_data, char_valid, char_count, overflow
  );
endinterface

// File: rtl/key_char_fifo.sv
// Scan-code to ASCII decoder with typematic suppression feeding a show-ahead FIFO.
// Optional macro KEY_SHIFT_CASE_EN: letters are lowercase unless shift is held.
module key_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  key_char_fifo_if.slave kbd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // {hit, ascii}; hit=0 for any code without a character.
  function automatic logic [8:0] map_code(input logic [8:0] code);
    case (code)
      9'h01C: map_code = {1'b1, 8'h41};
      9'h032: map_code = {1'b1, 8'h42};
      9'h021: map_code = {1'b1, 8'h43};
      9'h023: map_code = {1'b1, 8'h44};
      9'h024: map_code = {1'b1, 8'h45};
      9'h02B: map_code = {1'b1, 8'h46};
      9'h034: map_code = {1'b1, 8'h47};
      9'h033: map_code = {1'b1, 8'h48};
      9'h043: map_code = {1'b1, 8'h49};
      9'h03B: map_code = {1'b1, 8'h4A};
      9'h042: map_code = {1'b1, 8'h4B};
      9'h04B: map_code = {1'b1, 8'h4C};
      9'h03A: map_code = {1'b1, 8'h4D};
      9'h031: map_code = {1'b1, 8'h4E};
      9'h044: map_code = {1'b1, 8'h4F};
      9'h04D: map_code = {1'b1, 8'h50};
      9'h015: map_code = {1'b1, 8'h51};
      9'h02D: map_code = {1'b1, 8'h52};
      9'h01B: map_code = {1'b1, 8'h53};
      9'h02C: map_code = {1'b1, 8'h54};
      9'h03C: map_code = {1'b1, 8'h55};
      9'h02A: map_code = {1'b1, 8'h56};
      9'h01D: map_code = {1'b1, 8'h57};
      9'h022: map_code = {1'b1, 8'h58};
      9'h035: map_code = {1'b1, 8'h59};
      9'h01A: map_code = {1'b1, 8'h5A};
      9'h045: map_code = {1'b1, 8'h30};
      9'h016: map_code = {1'b1, 8'h31};
      9'h01E: map_code = {1'b1, 8'h32};
      9'h026: map_code = {1'b1, 8'h33};
      9'h025: map_code = {1'b1, 8'h34};
      9'h02E: map_code = {1'b1, 8'h35};
      9'h036: map_code = {1'b1, 8'h36};
      9'h03D: map_code = {1'b1, 8'h37};
      9'h03E: map_code = {1'b1, 8'h38};
      9'h046: map_code = {1'b1, 8'h39};
      9'h029: map_code = {1'b1, 8'h20};
      9'h066: map_code = {1'b1, 8'h08};
      9'h05A: map_code = {1'b1, 8'h0D};
      9'h171: map_code = {1'b1, 8'h7F};
      9'h175: map_code = {1'b1, 8'h01};
      9'h172: map_code = {1'b1, 8'h02};
      9'h16B: map_code = {1'b1, 8'h03};
      9'h174: map_code = {1'b1, 8'h04};
      default: map_code = 9'h000;
    endcase
  endfunction

  logic [1:0]    r_shift;
  logic          r_held_flag;
  logic [8:0]    r_held_code;
  logic          r_dec_valid;
  logic [7:0]    r_dec_char;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic [8:0]    w_map;
  logic [7:0]    w_case_char;
  logic [1:0]    w_shift_next;
  logic          w_is_shift;
  logic          w_repeat;
  logic          w_accept;
  logic          w_release_held;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  always_comb begin
    w_map        = map_code(kbd.last_change);
    w_is_shift   = (kbd.last_change == 9'h012) || (kbd.last_change == 9'h059);
    w_shift_next = r_shift;
    if (kbd.key_valid && w_is_shift) begin
      if (kbd.last_change == 9'h012) w_shift_next[0] = kbd.key_make;
      else                           w_shift_next[1] = kbd.key_make;
    end
    w_repeat       = r_held_flag && (kbd.last_change == r_held_code);
    w_accept       = kbd.key_valid && kbd.key_make && !w_is_shift && w_map[8] && !w_repeat;
    w_release_held = kbd.key_valid && !kbd.key_make && r_held_flag &&
                     (kbd.last_change == r_held_code);
  end

`ifdef KEY_SHIFT_CASE_EN
  always_comb begin
    w_case_char = w_map[7:0];
    if ((r_shift == 2'b00) && (w_map[7:0] >= 8'h41) && (w_map[7:0] <= 8'h5A))
      w_case_char = w_map[7:0] | 8'h20;
  end
`else
  always_comb begin
    w_case_char = w_map[7:0];
  end
`endif

  // Decode stage: held-key bookkeeping and the registered character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= 2'b00;
      r_held_flag <= 1'b0;
      r_held_code <= 9'h000;
      r_dec_valid <= 1'b0;
      r_dec_char  <= 8'h00;
    end else begin
      r_shift     <= w_shift_next;
      r_dec_valid <= w_accept;
      if (w_accept) begin
        r_dec_char  <= w_case_char;
        r_held_code <= kbd.last_change;
        r_held_flag <= 1'b1;
      end else if (w_release_held) begin
        r_held_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_empty = (r_count == '0);
    w_pop   = kbd.char_ready && !w_empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    w_push  = r_dec_valid && (!w_full || w_pop);
    w_drop  = r_dec_valid && w_full && !w_pop;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_dec_char;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign kbd.char_valid = !w_empty;
  assign kbd.char_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign kbd.char_count = r_count;
  assign kbd.overflow   = r_overflow;
endmodule

// File: tb/tb_key_char_fifo.sv
// Directed self-checking bench for key_char_fifo (DEPTH=8).
module tb_key_char_fifo;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  key_char_fifo_if #(.DEPTH(8)) kbd ();

  key_char_fifo #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .kbd (kbd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] code, input logic make);
    kbd.key_valid   = 1'b1;
    kbd.last_change = code;
    kbd.key_make    = make;
    tick();
    kbd.key_valid   = 1'b0;
    kbd.last_change = 9'h1FF;
    kbd.key_make    = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, kbd.char_data}, {24'h0, exp});
    kbd.char_ready = 1'b1;
    tick();
    kbd.char_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_lc;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    kbd.key_valid   = 1'b0;
    kbd.last_change = 9'h000;
    kbd.key_make    = 1'b0;
    kbd.char_ready  = 1'b0;
    tick();
    tick();
    check("rst_count", 32'(kbd.char_count), 32'd0);
    check("rst_valid", 32'(kbd.char_valid), 32'd0);
    check("rst_data",  32'(kbd.char_data),  32'h00);
    check("rst_ovf",   32'(kbd.overflow),   32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Single make: visible two cycles after the event, not one.
    send(9'h01C, 1'b1);
    check("lat_n1_valid", 32'(kbd.char_valid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(kbd.char_valid), 32'd1);
    check("lat_n2_data",  32'(kbd.char_data),  32'h41);
    check("lat_n2_count", 32'(kbd.char_count), 32'd1);
    tick();
    check("hold_count", 32'(kbd.char_count), 32'd1);
    pop_check("single_pop", 8'h41);
    check("single_empty", 32'(kbd.char_count), 32'd0);

    // Typematic repeat suppression.
    send(9'h01C, 1'b0);
    send(9'h01C, 1'b1);
    send(9'h01C, 1'b1);
    send(9'h01C, 1'b0);
    send(9'h01C, 1'b1);
    tick();
    check("rep_count", 32'(kbd.char_count), 32'd2);
    pop_check("rep_first", 8'h41);
    pop_check("rep_second", 8'h41);
    check("rep_empty", 32'(kbd.char_count), 32'd0);

    // Unmapped make is dropped and does not disturb held_code.
    send(9'h076, 1'b1);
    send(9'h01C, 1'b1);
    tick();
    tick();
    check("unmapped_count", 32'(kbd.char_count), 32'd0);
    send(9'h01C, 1'b0);

    // Nine makes into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      send((i % 2 == 0) ? 9'h016 : 9'h01E, 1'b1);
      send((i % 2 == 0) ? 9'h016 : 9'h01E, 1'b0);
    end
    tick();
    check("ovf_count", 32'(kbd.char_count), 32'd8);
    check("ovf_flag",  32'(kbd.overflow),   32'd1);
    check("ovf_head",  32'(kbd.char_data),  32'h31);
    for (int i = 0; i < 8; i++)
      pop_check("ovf_order", (i % 2 == 0) ? 8'h31 : 8'h32);
    check("ovf_drained", 32'(kbd.char_count), 32'd0);
    check("ovf_sticky",  32'(kbd.overflow),   32'd1);
    pulse_reset();
    check("ovf_reset", 32'(kbd.overflow), 32'd0);

    // Full FIFO with write and pop in the same cycle.
    for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 9'h016 : 9'h01E, 1'b1);
    tick();
    check("full_count", 32'(kbd.char_count), 32'd8);
    send(9'h01C, 1'b1);
    kbd.char_ready = 1'b1;
    tick();
    kbd.char_ready = 1'b0;
    check("fullrw_count", 32'(kbd.char_count), 32'd8);
    check("fullrw_ovf",   32'(kbd.overflow),   32'd0);
    for (int i = 0; i < 7; i++)
      pop_check("fullrw_order", (i % 2 == 0) ? 8'h32 : 8'h31);
    pop_check("fullrw_tail", 8'h41);
    check("fullrw_empty", 32'(kbd.char_count), 32'd0);

    // Empty FIFO with pending write while ready is high: pop ignored.
    kbd.char_ready = 1'b1;
    send(9'h02B, 1'b1);
    kbd.char_ready = 1'b1;
    tick();
    kbd.char_ready = 1'b0;
    check("emptyrw_count", 32'(kbd.char_count), 32'd1);
    pop_check("emptyrw_data", 8'h46);

    // Shift tracking and case handling.
`ifdef KEY_SHIFT_CASE_EN
    exp_lc = 8'h61;
`else
    exp_lc = 8'h41;
`endif
    send(9'h012, 1'b1);
    tick();
    tick();
    check("shift_noenq", 32'(kbd.char_count), 32'd0);
    send(9'h01C, 1'b1);
    tick();
    pop_check("shift_upper", 8'h41);
    send(9'h012, 1'b0);
    send(9'h01C, 1'b0);
    send(9'h01C, 1'b1);
    tick();
    pop_check("noshift_case", exp_lc);
    send(9'h059, 1'b1);
    send(9'h01C, 1'b0);
    send(9'h01C, 1'b1);
    tick();
    pop_check("rshift_upper", 8'h41);
    send(9'h059, 1'b0);
    send(9'h175, 1'b1);
    tick();
    pop_check("ext_175", 8'h01);
    check("shift_empty", 32'(kbd.char_count), 32'd0);

    // Reset while a character sits in the decode stage.
    send(9'h01A, 1'b1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("midrst_count", 32'(kbd.char_count), 32'd0);
    check("midrst_valid", 32'(kbd.char_valid), 32'd0);
    check("midrst_data",  32'(kbd.char_data),  32'h00);
    check("midrst_ovf",   32'(kbd.overflow),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_char_fifo.md
KEY_CHAR_FIFO -- requirements
Module: key_char_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_valid  input  1  one-cycle pulse, new scan event from the keyboard decoder.
REQ-005 SHALL have port last_change  input  9  scan code of the event; bit 8 = E0-extended.
REQ-006 SHALL have port key_make  input  1  sampled with key_valid; 1 = press, 0 = release.
REQ-007 SHALL have port char_ready  input  1  consumer accepts char_data this cycle.
REQ-008 SHALL have port char_data  output  8  ASCII code at FIFO head.
REQ-009 SHALL have port char_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port char_count  output  clog2(DEPTH)+1  entries held.
REQ-011 SHALL have port overflow  output  1  sticky; a character was dropped because the FIFO was full.

Function
REQ-012 SHALL sample last_change/key_make only on cycles with key_valid=1; other cycles ignore both.
REQ-013 SHALL track shift_held: set on make of 9'h012 or 9'h059, cleared when both are released (per-key flags); shift events enqueue nothing.
REQ-014 SHALL enqueue only make events; release events only update held-key state.
REQ-015 SHALL suppress typematic repeat: a make whose code equals held_code while held_flag=1 is dropped; a make of any other mapped code sets held_code and held_flag; a release of held_code clears held_flag.
REQ-016 SHALL map: 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> A..Z (41..5A); 45,16,1E,26,25,2E,36,3D,3E,46 -> 30..39; 29->20; 66->08; 5A->0D; 171->7F; 175->01; 172->02; 16B->03; 174->04.
REQ-017 SHALL drop make events of codes not listed in REQ-016 without changing held_code.
REQ-018 SHALL register the mapped character in a decode stage (cycle N+1) and write it to the FIFO at cycle N+2; char_valid rises at N+2 at the earliest (no combinational bypass).
REQ-019 SHALL pop when char_valid=1 and char_ready=1; char_ready with char_valid=0 has no effect.
REQ-020 SHALL present char_data show-ahead: head entry valid in the same cycle char_valid=1.
REQ-021 SHALL, on write when full without a same-cycle pop, drop the character, leave contents unchanged and set overflow.
REQ-022 SHALL accept a write and a pop in the same cycle at any fill level, including full (count unchanged) and empty-with-pending-write (count unchanged is not allowed: empty means pop is ignored, count +1).
REQ-023 SHALL wrap read/write pointers modulo DEPTH; char_count = DEPTH when full, 0 when empty.
REQ-024 SHALL preserve FIFO order of keystrokes.

Reset
REQ-025 SHALL on rst=1 asynchronously clear: pointers, char_count=0, char_valid=0, char_data=8'h00, overflow=0, shift flags, held_flag, held_code=9'h000, decode stage valid.
REQ-026 SHALL discard an in-flight decode-stage character when reset asserts mid-operation.
REQ-027 SHALL keep overflow set from first drop until reset.

Configuration
REQ-028 SHALL, with macro KEY_SHIFT_CASE_EN defined, output letters as lowercase (61..7A) when shift_held=0 and uppercase when shift_held=1; digits/others unaffected.
REQ-029 SHALL, without KEY_SHIFT_CASE_EN, output letters uppercase always; shift still tracked and still never enqueued.

Verification
REQ-030 SHALL verify: make 1C at cycle 10, char_ready=0 -> char_valid=1, char_data=41 from cycle 12, char_count=1.
REQ-031 SHALL verify: make 1C, make 1C (repeat), release 1C, make 1C -> exactly two 41 entries.
REQ-032 SHALL verify: DEPTH=8, nine distinct-key makes (alternating 16/1E with releases), no pops -> count=8, overflow=1, head=31, ninth char absent.
REQ-033 SHALL verify: full FIFO, write and char_ready=1 same cycle -> count stays 8, order preserved, overflow stays 0.
REQ-034 SHALL verify: make 012, make 1C, with KEY_SHIFT_CASE_EN -> 41; without shift -> 61; macro undefined -> 41 both cases; make 175 -> 01.
REQ-035 SHALL verify: rst pulse one cycle after key_valid -> no character ever appears, all outputs at reset values.
